seq_order_checker: RTL

- Parametrised successor of the lab-2 single-sequence FSM.
- Watches a stream of W-bit symbols and checks that LEN consecutive valid symbols form a strictly stepping run.
- The run's direction (ascending or descending) is auto-detected from its first two symbols.
- Flags completion (z), direction (D) and ordering violations (error, sticky). Sits between the stimulus/input stage and the result indicators of the lab board designs.

---
 rtl/seq_order_checker_pkg.sv | 22 ++
 rtl/seq_order_checker_step_cmp.sv | 30 +++
 rtl/seq_order_checker.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seq_order_checker_pkg.sv
// Shared types and constants for the sequence order checker.
// State encodings are kept as plain constants for compatibility with the
// existing lab-board state decode.
package seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t FIRST = 3'd1;
    localparam state_t TRACK = 3'd2;
    localparam state_t DONE  = 3'd3;
    localparam state_t ERR   = 3'd4;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Width needed to hold a count from 0 up to and including len.
    function automatic int unsigned prog_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/seq_order_checker_step_cmp.sv
// Combinational step comparator: is x one step above, one step below, or
// equal to the previous symbol. WRAP selects whether modulo wrap counts.
module seq_step_cmp #(
    parameter int unsigned W    = 3,
    parameter bit          WRAP = 1'b1
) (
    input  logic [W-1:0] last,
    input  logic [W-1:0] x,
    output logic         up,
    output logic         dn,
    output logic         same
);

    logic [W-1:0] inc;
    logic [W-1:0] dec;

    // Neighbour values and the wrap exclusions at the range ends.
    always_comb begin
        inc  = last + W'(1);
        dec  = last - W'(1);
        up   = (x == inc);
        dn   = (x == dec);
        same = (x == last);
        if (!WRAP) begin
            if (last == '1) up = 1'b0;
            if (last == '0) dn = 1'b0;
        end
    end

endmodule

// File: rtl/seq_order_checker.sv
// Sequence order checker: verifies that LEN consecutive valid symbols form a
// strictly stepping run whose direction is taken from the first two symbols.
// Optional build macro SEQ_REPEAT_TOLERANT_EN: a repeated symbol inside a run
// is silently ignored instead of being flagged as a violation.
module seq_order_checker
    import seq_pkg::*;
#(
    parameter int unsigned W    = 3,
    parameter int unsigned LEN  = 8,
    parameter bit          WRAP = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          x_valid,
    input  logic [W-1:0]                  x,
    input  logic                          clear,
    output logic                          z,
    output logic                          D,
    output logic                          error,
    output logic [prog_width(LEN)-1:0]    progress
);

    localparam int unsigned PW = prog_width(LEN);
    localparam logic [PW-1:0] PROG_LEN = PW'(LEN);

`ifdef SEQ_REPEAT_TOLERANT_EN
    localparam logic REPEAT_OK = 1'b1;
`else
    localparam logic REPEAT_OK = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [W-1:0]  last_q,  last_d;
    logic [PW-1:0] prog_q,  prog_d;
    logic          dir_q,   dir_d;
    logic          err_q,   err_d;
    logic          z_q,     z_d;

    logic          up;
    logic          dn;
    logic          same;
    logic [PW-1:0] prog_inc;

    seq_step_cmp #(
        .W    (W),
        .WRAP (WRAP)
    ) u_step_cmp (
        .last (last_q),
        .x    (x),
        .up   (up),
        .dn   (dn),
        .same (same)
    );

    assign prog_inc = prog_q + PW'(1);

    // Next-state logic: clear outranks symbol acceptance; z is a one-cycle pulse.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        prog_d  = prog_q;
        dir_d   = dir_q;
        err_d   = err_q;
        z_d     = 1'b0;

        if (clear) begin
            state_d = IDLE;
            err_d   = 1'b0;
            dir_d   = DIR_DN;
            prog_d  = '0;
        end else if (x_valid) begin
            case (state_q)
                IDLE, DONE: begin
                    last_d  = x;
                    prog_d  = PW'(1);
                    dir_d   = DIR_DN;
                    state_d = FIRST;
                end
                FIRST: begin
                    if (REPEAT_OK && same) begin
                        state_d = FIRST;
                    end else if (up || dn) begin
                        dir_d  = up ? DIR_UP : DIR_DN;
                        last_d = x;
                        prog_d = PW'(2);
                        if (PW'(2) == PROG_LEN) begin
                            state_d = DONE;
                            z_d     = 1'b1;
                        end else begin
                            state_d = TRACK;
                        end
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
                TRACK: begin
                    if (REPEAT_OK && same) begin
                        state_d = TRACK;
                    end else if ((dir_q == DIR_UP && up) || (dir_q == DIR_DN && dn)) begin
                        last_d = x;
                        prog_d = prog_inc;
                        if (prog_inc == PROG_LEN) begin
                            state_d = DONE;
                            z_d     = 1'b1;
                        end
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= '0;
            prog_q  <= '0;
            dir_q   <= DIR_DN;
            err_q   <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            prog_q  <= prog_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            z_q     <= z_d;
        end
    end

    assign z        = z_q;
    assign D        = dir_q;
    assign error    = err_q;
    assign progress = prog_q;

endmodule
